// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite types and constants shared by the frame-buffer
// slave and the LCD DMA master.
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htran_t;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'b000,
        HB_INCR   = 3'b001,
        HB_WRAP4  = 3'b010,
        HB_INCR4  = 3'b011,
        HB_WRAP8  = 3'b100,
        HB_INCR8  = 3'b101,
        HB_WRAP16 = 3'b110,
        HB_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [1:0] {
        HR_OKAY  = 2'b00,
        HR_ERROR = 2'b01,
        HR_RETRY = 2'b10,
        HR_SPLIT = 2'b11
    } hresp_t;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Slave data-phase states
    typedef enum logic [2:0] {
        D_NONE = 3'd0,
        D_WAIT = 3'd1,
        D_XFER = 3'd2,
        D_ERR1 = 3'd3,
        D_ERR2 = 3'd4
    } dphase_t;

    // Wait counter preset: one less than the number of low cycles
    function automatic logic [2:0] wait_init(input int ws);
        logic [2:0] r;
        r = 3'd0;
        if (ws > 0) r = 3'(ws - 1);
        return r;
    endfunction

endpackage

// File: rtl/ahb_fb_mem.sv
// ahb_fb_mem: word SRAM for the LCD frame buffer, synchronous read,
// bus write port with a backdoor preload port that yields on collision.
module ahb_fb_mem #(
    parameter int ADDR_W = 10
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [31:0]       bd_wdata
);

    logic [31:0] mem_q [2**ADDR_W];
    logic        bd_hit;
    logic        fwd_bus;
    logic        fwd_bd;

    assign bd_hit  = we && (bd_addr == waddr);
    assign fwd_bus = we && (waddr == raddr);
    assign fwd_bd  = bd_we && (bd_addr == raddr);

    // Array update: bus write beats a backdoor write to the same word
    always_ff @(posedge HCLK) begin
        if (we) mem_q[waddr] <= wdata;
        if (bd_we && !bd_hit) mem_q[bd_addr] <= bd_wdata;
    end

    // Registered read; data written on the same edge is forwarded
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            rdata <= '0;
        end else if (re) begin
            if (fwd_bus) rdata <= wdata;
            else if (fwd_bd) rdata <= bd_wdata;
            else rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/ahb_fb_slave.sv
// ahb_fb_slave: AHB-Lite slave fronting the LCD frame-buffer SRAM with
// optional wait states, two-cycle ERROR responses and protocol watch.
module ahb_fb_slave #(
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] BASE        = 32'h0,
    parameter int          WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              sHSEL,
    input  logic [31:0]       sHADDR,
    input  logic [1:0]        sHTRANS,
    input  logic              sHWRITE,
    input  logic [2:0]        sHSIZE,
    input  logic [2:0]        sHBURST,
    input  logic [31:0]       sHWDATA,
    input  logic              sHREADYIN,
    output logic              sHREADY,
    output logic [1:0]        sHRESP,
    output logic [31:0]       sHRDATA,
    output logic              sProtoErr,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [31:0]       bd_wdata
);

    import ahb_pkg::*;

    localparam logic [2:0] WS_INIT = wait_init(WAIT_STATES);
    localparam logic [31:ADDR_W+2] BASE_HI = BASE[31:ADDR_W+2];

    dphase_t           state;
    dphase_t           state_n;
    htran_t            trans;
    logic [2:0]        wcnt;
    logic              d_write;
    logic [ADDR_W-1:0] d_idx;
    logic              acc;
    logic              acc_err;
    logic              acc_ok;
    logic              size_bad;
    logic              align_bad;
    logic              range_bad;
    logic [ADDR_W-1:0] a_idx;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic              in_burst;
    logic              last_idle;
    logic [31:0]       prev_addr;
    logic              seq_bad;
    logic              busy_bad;
    logic              unused_burst;

    assign trans        = htran_t'(sHTRANS);
    assign unused_burst = ^sHBURST;

    assign acc       = sHSEL && sHREADYIN && sHTRANS[1] && sHREADY;
    assign size_bad  = sHSIZE != HSIZE_WORD;
    assign align_bad = sHADDR[1:0] != 2'b00;
    assign range_bad = sHADDR[31:ADDR_W+2] != BASE_HI;
    assign acc_err   = size_bad || align_bad || range_bad;
    assign acc_ok    = acc && !acc_err;

    // BASE is aligned to the memory span, so the offset is just the low bits
    assign a_idx  = sHADDR[ADDR_W+1:2];
    assign mem_re = acc_ok && !sHWRITE;
    assign mem_we = (state == D_XFER) && d_write;

    ahb_fb_mem #(
        .ADDR_W(ADDR_W)
    ) u_mem (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .we      (mem_we),
        .waddr   (d_idx),
        .wdata   (sHWDATA),
        .re      (mem_re),
        .raddr   (a_idx),
        .rdata   (mem_rdata),
        .bd_we   (bd_we),
        .bd_addr (bd_addr),
        .bd_wdata(bd_wdata)
    );

    // Data-phase state register
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) state <= D_NONE;
        else state <= state_n;
    end

    // Next data phase from the current one and any new acceptance
    always_comb begin
        state_n = D_NONE;
        case (state)
            D_WAIT: state_n = (wcnt == 3'd0) ? D_XFER : D_WAIT;
            D_ERR1: state_n = D_ERR2;
            default: begin
                if (acc) begin
                    if (acc_err) state_n = D_ERR1;
                    else if (WAIT_STATES > 0) state_n = D_WAIT;
                    else state_n = D_XFER;
                end
            end
        endcase
    end

    // Bus outputs decoded from the data-phase state
    always_comb begin
        sHREADY = 1'b1;
        sHRESP  = HR_OKAY;
        sHRDATA = mem_rdata;
        case (state)
            D_WAIT: sHREADY = 1'b0;
            D_ERR1: begin
                sHREADY = 1'b0;
                sHRESP  = HR_ERROR;
                sHRDATA = '0;
            end
            D_ERR2: begin
                sHRESP  = HR_ERROR;
                sHRDATA = '0;
            end
            default: ;
        endcase
    end

    // Latch address-phase control and run the wait countdown
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            wcnt    <= 3'd0;
            d_write <= 1'b0;
            d_idx   <= '0;
        end else begin
            if (acc) begin
                d_write <= sHWRITE && !acc_err;
                d_idx   <= a_idx;
                wcnt    <= WS_INIT;
            end else if ((state == D_WAIT) && (wcnt != 3'd0)) begin
                wcnt <= wcnt - 3'd1;
            end
        end
    end

    assign seq_bad  = acc && (trans == HT_SEQ) &&
                      (!in_burst || (sHADDR != prev_addr + 32'd4));
    assign busy_bad = sHSEL && sHREADYIN && (trans == HT_BUSY) && last_idle;

    // Burst tracking and the sticky protocol-violation flag
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            in_burst  <= 1'b0;
            last_idle <= 1'b1;
            prev_addr <= '0;
            sProtoErr <= 1'b0;
        end else begin
            if (acc) begin
                in_burst  <= 1'b1;
                prev_addr <= sHADDR;
            end else if (sHREADYIN && (!sHSEL || (trans == HT_IDLE))) begin
                in_burst <= 1'b0;
            end
            if (sHREADYIN) last_idle <= !sHSEL || (trans == HT_IDLE);
            if (seq_bad || busy_bad) sProtoErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb_fb_slave.sv
// tb_ahb_fb_slave: directed checks of ahb_fb_slave, one zero-wait and
// one two-wait instance sharing the bus and the backdoor.
module tb_ahb_fb_slave;

    import ahb_pkg::*;

    localparam int          ADDR_W = 10;
    localparam logic [31:0] BASE   = 32'h0000_4000;
    localparam logic [31:0] SPAN   = 32'd4 << ADDR_W;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic              hsel;
    logic              use2;
    logic [31:0]       haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [31:0]       hwdata;
    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [31:0]       bd_wdata;

    logic        sel0, sel2;
    logic        r0, r2;
    logic [1:0]  resp0, resp2;
    logic [31:0] rd0, rd2;
    logic        pe0, pe2;

    logic        cr;
    logic [1:0]  cresp;
    logic [31:0] crd;
    logic        cpe;

    int nt = 0;
    int nf = 0;

    assign sel0  = hsel && !use2;
    assign sel2  = hsel && use2;
    assign cr    = use2 ? r2 : r0;
    assign cresp = use2 ? resp2 : resp0;
    assign crd   = use2 ? rd2 : rd0;
    assign cpe   = use2 ? pe2 : pe0;

    always #5 HCLK = ~HCLK;

    ahb_fb_slave #(
        .ADDR_W(ADDR_W), .BASE(BASE), .WAIT_STATES(0)
    ) u_ws0 (
        .HCLK(HCLK), .HRESET(HRESET), .sHSEL(sel0), .sHADDR(haddr),
        .sHTRANS(htrans), .sHWRITE(hwrite), .sHSIZE(hsize),
        .sHBURST(hburst), .sHWDATA(hwdata), .sHREADYIN(r0),
        .sHREADY(r0), .sHRESP(resp0), .sHRDATA(rd0), .sProtoErr(pe0),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
    );

    ahb_fb_slave #(
        .ADDR_W(ADDR_W), .BASE(BASE), .WAIT_STATES(2)
    ) u_ws2 (
        .HCLK(HCLK), .HRESET(HRESET), .sHSEL(sel2), .sHADDR(haddr),
        .sHTRANS(htrans), .sHWRITE(hwrite), .sHSIZE(hsize),
        .sHBURST(hburst), .sHWDATA(hwdata), .sHREADYIN(r2),
        .sHREADY(r2), .sHRESP(resp2), .sHRDATA(rd2), .sProtoErr(pe2),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
    );

    typedef struct {
        logic        u2;
        logic        wr;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] erd;
        logic [1:0]  eresp;
        int          elows;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nt++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // One NONSEQ transfer followed by IDLE, data phase observed to its end
    task automatic xfer(input logic u2, input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output logic [1:0] resp, output logic [31:0] rdf,
                        output logic [31:0] rdl, output int lows);
        use2   = u2;
        hsel   = 1'b1;
        htrans = HT_NONSEQ;
        hburst = HB_SINGLE;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        step();
        hsel   = 1'b0;
        htrans = HT_IDLE;
        hwdata = wd;
        lows   = 0;
        rdf    = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge HCLK);
            if (k == 0) rdf = crd;
            if (cr) break;
            lows++;
        end
        resp = cresp;
        rdl  = crd;
        step();
    endtask

    logic [1:0]  x_resp;
    logic [31:0] x_rdf;
    logic [31:0] x_rdl;
    int          x_lows;
    logic [31:0] pa [4];
    logic [31:0] pd [4];
    logic        pp [4];

    initial begin
        HRESET   = 1'b0;
        hsel     = 1'b0;
        use2     = 1'b0;
        haddr    = '0;
        htrans   = HT_IDLE;
        hwrite   = 1'b0;
        hsize    = HSIZE_WORD;
        hburst   = HB_SINGLE;
        hwdata   = '0;
        bd_we    = 1'b0;
        bd_addr  = '0;
        bd_wdata = '0;

        #1;
        chk("rst_hready0", r0, 1);
        chk("rst_hresp0", resp0, HR_OKAY);
        chk("rst_hrdata0", rd0, 0);
        chk("rst_proto0", pe0, 0);
        chk("rst_hready2", r2, 1);
        chk("rst_hrdata2", rd2, 0);

        step();
        step();
        HRESET = 1'b1;
        step();

        // preload every word with A000_0000 + index
        bd_we = 1'b1;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            bd_addr  = ADDR_W'(i);
            bd_wdata = 32'hA000_0000 + 32'(i);
            step();
        end
        bd_we = 1'b0;

        // zero-wait INCR8 read: 8 beats across 9 cycles
        use2   = 1'b0;
        hwrite = 1'b0;
        hsize  = HSIZE_WORD;
        hburst = HB_INCR8;
        for (int b = 0; b < 9; b++) begin
            if (b < 8) begin
                hsel   = 1'b1;
                htrans = (b == 0) ? HT_NONSEQ : HT_SEQ;
                haddr  = BASE + 32'(4 * b);
            end else begin
                hsel   = 1'b0;
                htrans = HT_IDLE;
            end
            @(negedge HCLK);
            if (b > 0) begin
                chk($sformatf("incr8_beat%0d", b - 1),
                    {cr, 1'b0, cresp, crd[27:0]},
                    {1'b1, 1'b0, HR_OKAY, 28'(32'hA000_0000 + 32'(b - 1))});
                chk($sformatf("incr8_data%0d", b - 1), crd,
                    32'hA000_0000 + 32'(b - 1));
            end
            step();
        end
        chk("incr8_proto", cpe, 0);

        vt[0]  = '{1'b1, 1'b1, BASE + 32'h10, HSIZE_WORD, 32'hDEAD_BEEF,
                   1'b0, 32'h0, HR_OKAY, 2};
        vt[1]  = '{1'b1, 1'b0, BASE + 32'h10, HSIZE_WORD, 32'h0,
                   1'b1, 32'hDEAD_BEEF, HR_OKAY, 2};
        vt[2]  = '{1'b0, 1'b0, BASE + 32'h04, HSIZE_WORD, 32'h0,
                   1'b1, 32'hA000_0001, HR_OKAY, 0};
        vt[3]  = '{1'b0, 1'b0, BASE + SPAN, HSIZE_WORD, 32'h0,
                   1'b1, 32'h0, HR_ERROR, 1};
        vt[4]  = '{1'b0, 1'b1, BASE + 32'h30, 3'b001, 32'h0000_1234,
                   1'b1, 32'h0, HR_ERROR, 1};
        vt[5]  = '{1'b0, 1'b0, BASE + 32'h30, HSIZE_WORD, 32'h0,
                   1'b1, 32'hA000_000C, HR_OKAY, 0};
        vt[6]  = '{1'b0, 1'b0, BASE + 32'h32, HSIZE_WORD, 32'h0,
                   1'b1, 32'h0, HR_ERROR, 1};
        vt[7]  = '{1'b1, 1'b0, BASE + 32'h14, HSIZE_WORD, 32'h0,
                   1'b1, 32'hA000_0005, HR_OKAY, 2};
        vt[8]  = '{1'b1, 1'b0, BASE - 32'h4, HSIZE_WORD, 32'h0,
                   1'b1, 32'h0, HR_ERROR, 1};
        vt[9]  = '{1'b0, 1'b1, BASE + 32'h3C, HSIZE_WORD, 32'h5555_AAAA,
                   1'b0, 32'h0, HR_OKAY, 0};
        vt[10] = '{1'b0, 1'b0, BASE + 32'h3C, HSIZE_WORD, 32'h0,
                   1'b1, 32'h5555_AAAA, HR_OKAY, 0};
        vt[11] = '{1'b1, 1'b0, BASE + SPAN - 32'h4, HSIZE_WORD, 32'h0,
                   1'b1, 32'hA000_03FF, HR_OKAY, 2};

        for (int v = 0; v < 12; v++) begin
            xfer(vt[v].u2, vt[v].wr, vt[v].a, vt[v].sz, vt[v].wd,
                 x_resp, x_rdf, x_rdl, x_lows);
            chk($sformatf("vec%0d_resp", v), x_resp, vt[v].eresp);
            chk($sformatf("vec%0d_lows", v), x_lows, vt[v].elows);
            if (vt[v].chk_rd) begin
                chk($sformatf("vec%0d_rdata", v), x_rdl, vt[v].erd);
                chk($sformatf("vec%0d_rdata_first", v), x_rdf, vt[v].erd);
            end
        end

        // write then read of the same word, back to back
        use2   = 1'b0;
        hsel   = 1'b1;
        hburst = HB_SINGLE;
        htrans = HT_NONSEQ;
        hwrite = 1'b1;
        haddr  = BASE + 32'h20;
        step();
        hwrite = 1'b0;
        hwdata = 32'h1234_5678;
        @(negedge HCLK);
        chk("fwd_wr_ready", cr, 1);
        step();
        hsel   = 1'b0;
        htrans = HT_IDLE;
        @(negedge HCLK);
        chk("fwd_rd_data", crd, 32'h1234_5678);
        chk("fwd_rd_resp", cresp, HR_OKAY);
        step();
        xfer(1'b0, 1'b0, BASE + 32'h20, HSIZE_WORD, 32'h0,
             x_resp, x_rdf, x_rdl, x_lows);
        chk("fwd_mem_data", x_rdl, 32'h1234_5678);

        // reset while the first INCR4 write beat is waiting
        use2   = 1'b1;
        hsel   = 1'b1;
        hwrite = 1'b1;
        hsize  = HSIZE_WORD;
        hburst = HB_INCR4;
        htrans = HT_NONSEQ;
        haddr  = BASE + 32'h40;
        step();
        htrans = HT_SEQ;
        haddr  = BASE + 32'h44;
        hwdata = 32'hBAD0_0001;
        @(negedge HCLK);
        chk("rstmid_wait", cr, 0);
        #1;
        HRESET = 1'b0;
        #1;
        chk("rstmid_hready", cr, 1);
        chk("rstmid_hresp", cresp, HR_OKAY);
        chk("rstmid_hrdata", crd, 0);
        hsel   = 1'b0;
        htrans = HT_IDLE;
        hwrite = 1'b0;
        step();
        step();
        HRESET = 1'b1;
        step();
        xfer(1'b1, 1'b0, BASE + 32'h40, HSIZE_WORD, 32'h0,
             x_resp, x_rdf, x_rdl, x_lows);
        chk("rstmid_unwritten", x_rdl, 32'hA000_0010);

        // INCR4 read whose second beat jumps 0x00 -> 0x08
        use2 = 1'b0;
        chk("proto_clear", cpe, 0);
        pa = '{32'h00, 32'h08, 32'h0C, 32'h10};
        pd = '{32'hA000_0000, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
        pp = '{1'b0, 1'b1, 1'b1, 1'b1};
        hwrite = 1'b0;
        hburst = HB_INCR4;
        for (int b = 0; b < 5; b++) begin
            if (b < 4) begin
                hsel   = 1'b1;
                htrans = (b == 0) ? HT_NONSEQ : HT_SEQ;
                haddr  = BASE + pa[b];
            end else begin
                hsel   = 1'b0;
                htrans = HT_IDLE;
            end
            @(negedge HCLK);
            if (b > 0) begin
                chk($sformatf("proto_data%0d", b - 1), crd, pd[b-1]);
                chk($sformatf("proto_flag%0d", b - 1), cpe, pp[b-1]);
            end
            step();
        end
        xfer(1'b0, 1'b0, BASE + 32'h08, HSIZE_WORD, 32'h0,
             x_resp, x_rdf, x_rdl, x_lows);
        chk("proto_after_data", x_rdl, 32'hA000_0002);
        chk("proto_sticky", cpe, 1);

        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule

// File: doc/ahb_fb_slave.md
# ahb_fb_slave

AHB slave that backs the LCD frame buffer: a word-organised SRAM which the LCD DMA master reads with SINGLE/INCR/INCR4/INCR8 bursts and which a CPU-side master writes. Serves zero-wait or programmable-wait transfers, enforces word-only access and address range with two-cycle ERROR responses, and exposes a backdoor load port so benches can preload frames. Sits on the AHB slave side of the decoder/mux, opposite the LCD DMA master.

## Interface
- ADDR_W, 10: log2 of memory depth in 32-bit words (default 4 KB).
- BASE, 32'h0: byte base address; must be aligned to 4·2^ADDR_W.
- WAIT_STATES, 0: HREADY-low cycles per OKAY data phase, 0..7.

- HCLK  in  1  bus clock; all state updates on its rising edge.
- HRESET  in  1  asynchronous, active-low reset.
- sHSEL  in  1  slave select from decoder.
- sHADDR  in  32  address-phase address.
- sHTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- sHWRITE  in  1  1=write.
- sHSIZE  in  3  only 3'b010 (word) is legal.
- sHBURST  in  3  SINGLE/INCR/INCR4/INCR8; informational.
- sHWDATA  in  32  write data, valid in data phase.
- sHREADYIN  in  1  bus-level HREADY from the mux.
- sHREADY  out  1  slave ready.
- sHRESP  out  2  OKAY=00, ERROR=01 (RETRY/SPLIT never driven).
- sHRDATA  out  32  read data.
- sProtoErr  out  1  sticky protocol-violation flag.
- bd_we  in  1  backdoor write strobe (tests/preload).
- bd_addr  in  ADDR_W  backdoor word address.
- bd_wdata  in  32  backdoor write data.

## Operation
- Address phase accepted when sHSEL && sHREADYIN && sHTRANS[1]. IDLE/BUSY, or unselected: no access; next data phase is zero-wait OKAY.
- Accepted transfer is an error if sHSIZE≠010, sHADDR[1:0]≠0, or sHADDR outside [BASE, BASE+4·2^ADDR_W). Error transfers never touch memory.
- Data-phase FSM: D_NONE (sHREADY=1, OKAY), D_WAIT (sHREADY=0, OKAY, counts down), D_XFER (sHREADY=1, OKAY), D_ERR1 (sHREADY=0, ERROR), D_ERR2 (sHREADY=1, ERROR).
- On acceptance: error → D_ERR1; else WAIT_STATES>0 → D_WAIT with counter=WAIT_STATES−1; else D_XFER. D_WAIT → D_XFER when counter=0. D_ERR1 → D_ERR2 always. From D_XFER/D_ERR2/D_NONE: next per new acceptance, else D_NONE.
- Reads: synchronous SRAM read issued on the acceptance edge; sHRDATA registered, held stable through D_WAIT, until next read data phase. sHRDATA=0 during error phases.
- Writes: memory written on the edge ending D_XFER with sHWDATA, word index = (addr−BASE)>>2.
- Read-after-write hazard: read accepted in the same cycle a write completes to the same word returns sHWDATA (forwarded), not stale memory.
- sProtoErr set (never cleared except reset) on: SEQ accepted with no preceding accepted NONSEQ/SEQ in the same burst, or SEQ address ≠ previous address+4, or BUSY following IDLE. Transfer still executes normally.
- Backdoor: bd_we writes memory on any edge; bus write to same word in same cycle wins.

## Timing
- Reset (async assert): state D_NONE, sHREADY=1, sHRESP=OKAY, sHRDATA=0, sProtoErr=0, counters 0. Memory contents undefined/retained; not cleared. Reset mid-burst aborts without memory write.
- Address accepted at edge N: OKAY data phase completes (sHREADY=1) in cycle N+1+WAIT_STATES.
- Error: cycle N+1 sHREADY=0/ERROR, cycle N+2 sHREADY=1/ERROR.
- Zero-wait INCR8 read: 8 beats in 9 cycles, fully pipelined.
- Next address phase is accepted only in a cycle with sHREADY=1 (via sHREADYIN).
- Wait counter width 3 bits; no wrap beyond WAIT_STATES.

## Structure
- Shared package ahb_pkg: htran_t, hburst_t, hresp_t, HSIZE_WORD constant; common with the DMA master.
- Sub-module ahb_fb_mem: 2^ADDR_W×32 single-write-port SRAM with synchronous read and backdoor port arbitration.

## Test plan
- Backdoor preload word i = 32'hA000_0000+i; INCR8 read from BASE, WAIT_STATES=0 → 8 OKAY beats, data A000_0000..A000_0007, 9 cycles.
- WAIT_STATES=2, SINGLE write 32'hDEAD_BEEF to BASE+0x10, then read → each phase 2 low cycles; read returns DEAD_BEEF.
- Write BASE+0x20 immediately followed by read BASE+0x20 → forwarded value returned, no stale data.
- Read at BASE+4·2^ADDR_W and sHSIZE=001 access → ERROR two-cycle response each, memory unchanged.
- SEQ address jump (0x00→0x08) within INCR4 → sProtoErr=1 and stays 1; data still returned.
- Reset asserted mid INCR4 write during D_WAIT → outputs to reset values immediately; beat not written.
